// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // RISC-V funct3 width/sign encodings for loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: store byte enables and
// data replication, the legality check, and load lane extract/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Request side: decode width, check alignment, build lanes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    legal     = 1'b0;
    be        = 4'b0000;
    wdata_rep = wdata;
    case (funct3)
      F3_B: begin
        legal     = 1'b1;
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      F3_H: begin
        legal     = ~offset[0];
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
      end
      F3_W: begin
        legal = (offset == 2'b00);
        be    = 4'b1111;
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        legal = ~we;
        be    = 4'b0001 << offset;
      end
      F3_HU: begin
        legal = ~we & ~offset[0];
        be    = 4'b0011 << offset;
      end
      default: legal = 1'b0;
    endcase
  end

  // Response side: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    case (ld_offset)
      2'd0:    byte_lane = rdata_raw[7:0];
      2'd1:    byte_lane = rdata_raw[15:8];
      2'd2:    byte_lane = rdata_raw[23:16];
      default: byte_lane = rdata_raw[31:24];
    endcase
    half_lane = ld_offset[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    ld_data = {{16{half_lane[15]}}, half_lane};
      F3_W:    ld_data = rdata_raw;
      F3_BU:   ld_data = {24'd0, byte_lane};
      F3_HU:   ld_data = {16'd0, half_lane};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the single-cycle core datapath and a req/ack data
// memory. Stalls the core from acceptance until the DONE cycle.
// Optional: define LSU_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
// BUSY cycles without mem_ack (reported on lsu_fault).
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        lsu_exc,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu_mem_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_e  state;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        legal;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Value held during the last permitted ack-less BUSY cycle; the increment
  // taken at that edge would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  lsu_align u_align (
    .we        (req_we),
    .funct3    (funct3),
    .offset    (addr[1:0]),
    .wdata     (wdata),
    .legal     (legal),
    .be        (be_fmt),
    .wdata_rep (wdata_fmt),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .rdata_raw (mem_rdata),
    .ld_data   (ld_data)
  );

  // The accept cycle and every BUSY cycle freeze the core; an illegal access
  // raises lsu_exc instead and never stalls. Both are held low in reset.
  assign stall   = reset & (((state == IDLE) & req_valid & legal) | (state == BUSY));
  assign lsu_exc = reset & (state == IDLE) & req_valid & ~legal;

  // Access sequencer: accept in IDLE, hold the request until ack, one DONE
  // cycle for the core to commit, then back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata_out <= 32'd0;
      lsu_fault <= 1'b0;
      ld_funct3 <= 3'b000;
      ld_offset <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (req_valid && legal) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_be    <= be_fmt;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_fmt;
            ld_funct3 <= funct3;
            ld_offset <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          // An ack arriving with the timeout still completes normally.
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rdata_out <= mem_we ? 32'd0 : ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            rdata_out <= 32'd0;
            lsu_fault <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          // Unconditional: the same instruction's req_valid is still high here.
          state     <= IDLE;
          rdata_out <= 32'd0;
          lsu_fault <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed steps plus randomized
// accesses against an arithmetic reference model of the lane rules.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        lsu_exc;
  logic        lsu_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata_out (rdata_out),
    .lsu_exc   (lsu_exc),
    .lsu_fault (lsu_fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 when the funct3 is not valid for the direction.
  function automatic int m_size(input bit we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        3'd0: return 1;
        3'd1: return 2;
        3'd2: return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(we, f3);
    return (sz != 0) && ((a % 4) % sz == 0);
  endfunction

  function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
    logic [3:0] r = 4'b0000;
    for (int i = 0; i < sz; i++) r[(a % 4) + i] = 1'b1;
    return r;
  endfunction

  // Each byte lane i carries byte (i mod size) of the store data.
  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
    logic [31:0] r = 32'd0;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = wd >> (8 * (i % sz));
      r[8*i +: 8] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int sz = m_size(1'b0, f3);
    int bits = 8 * sz;
    logic [31:0] t = rd >> (8 * (a % 4));
    longint v;
    if (sz == 4) return t;
    v = longint'(t) & ((longint'(1) << bits) - 1);
    if (f3[2] == 1'b0 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // One complete instruction: present it, answer the memory port after
  // ack_at BUSY cycles, and check every cycle against the model.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                        input string tag);
    int sz;
    int k;
    bit timed_out;
    bit ack_seen;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
    #1;
    sz = m_size(we, f3);
    if (!m_legal(we, f3, a)) begin
      check({tag, " exc"}, lsu_exc, 1);
      check({tag, " exc stall"}, stall, 0);
      check({tag, " exc req"}, mem_req, 0);
      @(posedge clk); #1;
      check({tag, " exc req after"}, mem_req, 0);
      check({tag, " exc rdata"}, rdata_out, 0);
      req_valid = 1'b0;
      return;
    end
    check({tag, " accept exc"}, lsu_exc, 0);
    check({tag, " accept stall"}, stall, 1);
    check({tag, " accept req"}, mem_req, 0);
    @(posedge clk);
    k = 0; timed_out = 1'b0;
    while (1) begin
      @(negedge clk);
      k++;
      check({tag, " busy req"}, mem_req, 1);
      check({tag, " busy stall"}, stall, 1);
      check({tag, " busy exc"}, lsu_exc, 0);
      check({tag, " busy addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, " busy we"}, mem_we, we);
      if (we) begin
        check({tag, " busy be"}, mem_be, m_be(sz, a));
        check({tag, " busy wdata"}, mem_wdata, m_wdata(sz, wd));
      end
      // Request fields change under a held req_valid; they must be ignored.
      addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); req_we = 1'($urandom);
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      ack_seen = mem_ack;
      mem_ack = 1'b0;
      if (ack_seen) break;
      if (TMO_EN && k == TO) begin
        timed_out = 1'b1;
        break;
      end
      if (k >= 300) begin
        check({tag, " ack bound"}, mem_req, 0);
        break;
      end
    end
    exp_rd = (timed_out || we) ? 32'd0 : m_load(f3, a, rd);
    @(negedge clk);
    check({tag, " done stall"}, stall, 0);
    check({tag, " done req"}, mem_req, 0);
    check({tag, " done rdata"}, rdata_out, exp_rd);
    check({tag, " done fault"}, lsu_fault, timed_out);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; req_valid = 1'b0;
    #1;
    check({tag, " idle rdata"}, rdata_out, 0);
    check({tag, " idle req"}, mem_req, 0);
    check({tag, " idle fault"}, lsu_fault, 0);
    check({tag, " idle stall"}, stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r_we;
    logic [2:0] r_f3;
    logic [31:0] r_rd;

    // Reset with a legal request pending: everything quiet, stall forced low.
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0100; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    check("rst stall", stall, 0);
    check("rst exc", lsu_exc, 0);
    check("rst req", mem_req, 0);
    check("rst we", mem_we, 0);
    check("rst be", mem_be, 0);
    check("rst addr", mem_addr, 0);
    check("rst wdata", mem_wdata, 0);
    check("rst rdata", rdata_out, 0);
    check("rst fault", lsu_fault, 0);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;

    access(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 2, "sw");
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'd0, 1, "sb");
    access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'd0, 1, "sh");
    access(1'b0, 3'b000, 32'h0000_1002, 32'd0, 32'h80F1_7F22, 1, "lb");
    access(1'b0, 3'b100, 32'h0000_1002, 32'd0, 32'h80F1_7F22, 1, "lbu");
    access(1'b0, 3'b001, 32'h0000_1002, 32'd0, 32'h80F1_7F22, 2, "lh");
    access(1'b0, 3'b101, 32'h0000_1002, 32'd0, 32'h80F1_7F22, 3, "lhu");
    access(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1, "lw misaligned");
    access(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 1, "load f3 011");
    access(1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 1, "store f3 100");

    // Ack while idle must not start or complete anything.
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("idle ack req", mem_req, 0);
    check("idle ack rdata", rdata_out, 0);
    check("idle ack stall", stall, 0);
    mem_ack = 1'b0;

    // Reset asserted mid-access abandons the request immediately.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    check("pre-rst busy req", mem_req, 1);
    reset = 1'b0;
    #1;
    check("mid rst req", mem_req, 0);
    check("mid rst stall", stall, 0);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("post rst req", mem_req, 0);
    check("post rst stall", stall, 0);
    access(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, 1, "lw after rst");

    // Randomized accesses, including illegal widths and misalignments.
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom);
      r_f3 = 3'($urandom_range(0, 7));
      r_rd = $urandom;
      access(r_we, r_f3, $urandom, $urandom, r_rd, $urandom_range(1, 3), "rand");
    end

`ifdef LSU_TIMEOUT_EN
    access(1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'h1111_2222, 100, "timeout");
    access(1'b0, 3'b010, 32'h0000_0404, 32'd0, 32'h3333_4444, TO, "ack at limit");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that sits directly downstream of the core datapath. It takes the ALU address result and the rs2 store data, and drives a request/acknowledge data-memory port. It returns formatted load data to the datapath's result mux and raises a stall so the single-cycle core freezes its PC and register-file write until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, number of BUSY cycles without mem_ack before the access is aborted (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  core clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
req_valid  in  1  current instruction is a load or store.
req_we  in  1  1 = store, 0 = load.
funct3  in  3  RISC-V width/sign field.
addr  in  32  byte address (ALU result).
wdata  in  32  store data (rs2).
stall  out  1  freeze PC and regfile write this cycle.
rdata_out  out  32  formatted, extended load data.
lsu_exc  out  1  misaligned or illegal-funct3 access this cycle.
lsu_fault  out  1  access aborted by timeout.
mem_req  out  1  memory request, held until ack.
mem_we  out  1  write strobe.
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables.
mem_ack  in  1  memory completion; ignored while mem_req=0.
mem_rdata  in  32  raw word read data, valid with mem_ack.

Behaviour:
- Reset values (async, while reset=0): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata_out, lsu_exc, lsu_fault all 0; stall forced 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req_valid=1 and the access is legal → register mem_addr/mem_we/mem_be/mem_wdata; go to BUSY.
  - stall is combinationally 1 in this cycle.
- BUSY:
  - mem_req=1, stall=1, all request fields held stable.
  - On mem_ack=1: capture the formatted mem_rdata into rdata_out (loads only; stores leave it at 0); drop mem_req on the next edge; go to DONE.
- DONE:
  - stall=0; rdata_out valid; the core commits at the end of this cycle.
  - Unconditional return to IDLE, so the still-high req_valid of the same instruction is not reissued.
  - rdata_out clears to 0 on return to IDLE.
- Minimum latency: 3 cycles (IDLE, BUSY with same-cycle ack, DONE).
- Store formatting:
  - SB (f3=000): be=0001<<addr[1:0]; byte replicated ×4.
  - SH (f3=001): be=0011<<addr[1:0]; halfword replicated ×2.
  - SW (f3=010): be=1111.
- Load formatting (lane selected by registered addr[1:0]):
  - LB (000): sign-extend byte.
  - LH (001): sign-extend halfword.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend halfword.
- Illegal or misaligned access:
  - Triggers: halfword with addr[0]=1; word with addr[1:0]≠0; load f3 ∈ {011,110,111}; store f3 > 010.
  - Response: lsu_exc=1 combinationally, stall=0, no mem_req, FSM stays in IDLE, rdata_out=0.
- Boundary and simultaneous events:
  - mem_ack in IDLE or DONE is ignored.
  - A second req_valid during BUSY or DONE is ignored; a new access is accepted only from IDLE.
  - Reset mid-access: mem_req drops immediately and the access is abandoned; memory must tolerate a withdrawn request.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: go to DONE with rdata_out=0, mem_req dropped, lsu_fault=1 for the DONE cycle only.
  - An ack in the same cycle as the timeout wins (normal completion).
- Not defined: BUSY waits indefinitely; lsu_fault tied 0; no counter logic.

Decomposition:
- Package lsu_pkg:
  - lsu_state_e enum (IDLE, BUSY, DONE).
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
- Sub-module lsu_align (combinational):
  - Store lane formatting: be and wdata replication.
  - Load extract and extension.
  - Legality check driving lsu_exc.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, ack after 2 BUSY cycles → mem_addr=0x104, be=1111, mem_wdata=0xDEADBEEF; stall high 3 cycles then low in DONE.
- SB addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
- Load mem_rdata=0x80F17F22, addr low bits=10:
  - LB → 0xFFFFFFF1.
  - LBU → 0x000000F1.
  - LH → 0xFFFF80F1.
  - LHU → 0x000080F1.
- LW addr=0x102 → lsu_exc=1, stall=0, mem_req never asserted; load f3=011 → same.
- Reset driven low while in BUSY → mem_req=0 and stall=0 immediately; after release, state IDLE and a new LW completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → lsu_fault=1 exactly one cycle after 4 BUSY cycles, rdata_out=0; ack on the 4th BUSY cycle → normal completion, no fault.
